lii_stream_packer: RTL and testbench
====================================

Name: lii_stream_packer

Overview:
- Kernel-to-fabric transmit end of the LII stream interface.
- Accepts the NIN=3 logical AXI-Stream outputs of an HLS kernel (a wide activation lane and two byte lanes), each with independent valid/ready.
- Buffers each lane in a one-entry holding register, packs one beat from every lane into a single PW-bit LII phy beat, and emits it from a registered output stage tagged with fixed src/dst IDs.
- Sits between a producing kernel and the LII phy output port of a layer's stream tile.

Parameters:
- PW, 256, LII phy packing width in bits.
- W0, 128, lane 0 data width.
- W1, 8, lane 1 data width.
- W2, 8, lane 2 data width.
- SRC_ID, 8'd0, value driven on lii_out_p0_src.
- DST_ID, 8'd1, value driven on lii_out_p0_dst.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- arstn  in  1  asynchronous active-low reset.
- s0_tdata  in  W0  lane 0 data.
- s0_tvalid  in  1  lane 0 valid.
- s0_tready  out  1  lane 0 ready.
- s1_tdata  in  W1  lane 1 data.
- s1_tvalid  in  1  lane 1 valid.
- s1_tready  out  1  lane 1 ready.
- s2_tdata  in  W2  lane 2 data.
- s2_tvalid  in  1  lane 2 valid.
- s2_tready  out  1  lane 2 ready.
- lii_out_p0_tdata  out  PW  packed beat.
- lii_out_p0_tvalid  out  1  beat valid.
- lii_out_p0_tready  in  1  phy ready.
- lii_out_p0_src  out  8  constant SRC_ID.
- lii_out_p0_dst  out  8  constant DST_ID.
- beat_cnt  out  32  count of LII beats handed off.

Behaviour:
- Reset:
  - Asynchronous on arstn low.
  - All lane full flags = 0; lii_out_p0_tvalid = 0; lii_out_p0_tdata = 0; beat_cnt = 0.
  - sN_tready = 1 after reset release.
  - Reset mid-operation discards partial and pending beats silently.
- Lane register, per lane i:
  - Holds one beat; full_i flag.
  - s_i_tready = !full_i | fire.
  - Lane accept (s_i_tvalid & s_i_tready) loads data and sets full_i.
  - full_i clears on fire unless a new beat is accepted in the same cycle; in that case it stays set with the new data.
- Output stage:
  - out_free = !lii_out_p0_tvalid | lii_out_p0_tready.
  - fire = full_0 & full_1 & full_2 & out_free.
  - On fire, the output register loads the packed word and sets tvalid.
  - Packed word: lane0 at [W0-1:0], lane1 at [W0+W1-1:W0], lane2 at [W0+W1+W2-1:W0+W1], upper bits 0.
  - If tvalid and tready with no fire, tvalid clears.
  - While tvalid & !tready, tdata and tvalid hold stable (AXI-S rule); no combinational path from any input to lii_out_p0_tdata.
- Latency:
  - Last missing lane accepted at edge t -> lii_out_p0_tvalid high after edge t+1.
- Throughput:
  - One LII beat per cycle sustained when all lanes present valid each cycle and tready is held high.
- Backpressure:
  - A lane that arrives early stalls only itself (tready low once full).
  - Other lanes are never blocked by a full lane, up to their own holding register.
- beat_cnt:
  - Increments on lii_out_p0_tvalid & lii_out_p0_tready.
  - Wraps 2^32-1 -> 0.
- Elaboration error if W0+W1+W2 > PW.
- src and dst are constant and not registered.

Decomposition:
- Package lii_pkg: LII_ID_W=8, default LII_PW=256, localparam helper for lane bit offsets.
- Sub-module lii_lane_reg: parameterised-width one-entry holding register with full flag, ready output and clear/reload on fire. Instantiated once per lane.
- Output register and counter live in the top.

Test Plan:
- Single beat:
  - Stimulus: after reset, s0=128'h0123..EF, s1=8'hA5, s2=8'h3C all valid for one cycle; tready=1.
  - Required: exactly one beat with tdata[143:0]={8'h3C,8'hA5,s0}, upper bits 0, src=0, dst=1; beat_cnt=1; tvalid high exactly 2 edges after the lane accept.
- Staggered lanes:
  - Stimulus: s0 at cycle 0, s1 at cycle 3, s2 at cycle 7.
  - Required: s0_tready low cycles 1-7; one output beat after edge 8; no beat earlier.
- Sink stall:
  - Stimulus: tready=0 for 10 cycles while 3 full beat sets are offered.
  - Required: tdata/tvalid stable through the stall; lanes accept at most 2 sets (1 in output + 1 in holding); all sets delivered in order once tready=1.
- Streaming throughput:
  - Stimulus: 1000 random beats on all lanes continuously; tready=1.
  - Required: 1000 output beats in 1001-1002 cycles; scoreboard matches; beat_cnt=1000.
- Random backpressure:
  - Stimulus: random valid on each lane and random tready at 50%.
  - Required: zero loss, duplication or reordering; AXI-S stability assertions hold.
- Reset mid-operation:
  - Stimulus: arstn low while lane0 is full and output is valid.
  - Required: tvalid=0 and beat_cnt=0 immediately (asynchronous); first post-reset beat contains only post-reset data.

Source files
------------

// File: rtl/lii_pkg.sv
// lii_pkg: shared LII widths and lane bit-offset helper
package lii_pkg;

    localparam int LII_ID_W = 8;
    localparam int LII_PW   = 256;

    function automatic int lane_lo(input int w0, input int w1, input int idx);
        return (idx == 0) ? 0 : (idx == 1) ? w0 : w0 + w1;
    endfunction

endpackage

// File: rtl/lii_lane_reg.sv
// lii_lane_reg: one-entry holding register for a single input lane
module lii_lane_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_fire,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_acc;

    assign o_ready = ~r_full | i_fire;
    assign w_acc   = i_valid & o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // Load on accept; the slot empties on fire unless refilled in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            r_full <= w_acc | (r_full & ~i_fire);
            if (w_acc) r_data <= i_data;
        end
    end

endmodule

// File: rtl/lii_stream_packer.sv
// lii_stream_packer: packs one beat from each of three lanes into a registered LII beat
module lii_stream_packer
    import lii_pkg::*;
#(
    parameter int                  PW     = LII_PW,
    parameter int                  W0     = 128,
    parameter int                  W1     = 8,
    parameter int                  W2     = 8,
    parameter logic [LII_ID_W-1:0] SRC_ID = 8'd0,
    parameter logic [LII_ID_W-1:0] DST_ID = 8'd1
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [W0-1:0]       s0_tdata,
    input  logic                s0_tvalid,
    output logic                s0_tready,
    input  logic [W1-1:0]       s1_tdata,
    input  logic                s1_tvalid,
    output logic                s1_tready,
    input  logic [W2-1:0]       s2_tdata,
    input  logic                s2_tvalid,
    output logic                s2_tready,
    output logic [PW-1:0]       lii_out_p0_tdata,
    output logic                lii_out_p0_tvalid,
    input  logic                lii_out_p0_tready,
    output logic [LII_ID_W-1:0] lii_out_p0_src,
    output logic [LII_ID_W-1:0] lii_out_p0_dst,
    output logic [31:0]         beat_cnt
);

    localparam int L0 = lane_lo(W0, W1, 0);
    localparam int L1 = lane_lo(W0, W1, 1);
    localparam int L2 = lane_lo(W0, W1, 2);

    if (W0 + W1 + W2 > PW) begin : g_width_check
        $error("lii_stream_packer: lane widths exceed PW");
    end

    logic [W0-1:0] w_d0;
    logic [W1-1:0] w_d1;
    logic [W2-1:0] w_d2;
    logic [2:0]    w_full;
    logic          w_out_free;
    logic          w_fire;
    logic [PW-1:0] w_pack;
    logic [PW-1:0] r_data;
    logic          r_valid;
    logic [31:0]   r_cnt;

    assign w_out_free = ~r_valid | lii_out_p0_tready;
    assign w_fire     = &w_full & w_out_free;

    lii_lane_reg #(.W(W0)) u_lane0 (
        .i_clk(aclk), .i_rst_n(arstn), .i_data(s0_tdata), .i_valid(s0_tvalid),
        .o_ready(s0_tready), .i_fire(w_fire), .o_data(w_d0), .o_full(w_full[0])
    );

    lii_lane_reg #(.W(W1)) u_lane1 (
        .i_clk(aclk), .i_rst_n(arstn), .i_data(s1_tdata), .i_valid(s1_tvalid),
        .o_ready(s1_tready), .i_fire(w_fire), .o_data(w_d1), .o_full(w_full[1])
    );

    lii_lane_reg #(.W(W2)) u_lane2 (
        .i_clk(aclk), .i_rst_n(arstn), .i_data(s2_tdata), .i_valid(s2_tvalid),
        .o_ready(s2_tready), .i_fire(w_fire), .o_data(w_d2), .o_full(w_full[2])
    );

    // Place each lane at its fixed offset; unused upper bits stay zero
    always_comb begin
        w_pack           = '0;
        w_pack[L0 +: W0] = w_d0;
        w_pack[L1 +: W1] = w_d1;
        w_pack[L2 +: W2] = w_d2;
    end

    // Output register: load on fire, drop valid once taken, hold while stalled
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_data  <= w_pack;
            r_valid <= 1'b1;
        end else if (lii_out_p0_tready) begin
            r_valid <= 1'b0;
        end
    end

    // Count beats handed to the phy; wraps naturally at 2^32
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) r_cnt <= '0;
        else if (r_valid && lii_out_p0_tready) r_cnt <= r_cnt + 32'd1;
    end

    assign lii_out_p0_tdata  = r_data;
    assign lii_out_p0_tvalid = r_valid;
    assign lii_out_p0_src    = SRC_ID;
    assign lii_out_p0_dst    = DST_ID;
    assign beat_cnt          = r_cnt;

endmodule

// File: tb/tb_lii_stream_packer.sv
// tb_lii_stream_packer: directed and scoreboarded checks of the LII stream packer
module tb_lii_stream_packer;

    logic         aclk = 1'b0;
    logic         arstn;
    logic [127:0] s0_tdata;
    logic         s0_tvalid;
    logic         s0_tready;
    logic [7:0]   s1_tdata;
    logic         s1_tvalid;
    logic         s1_tready;
    logic [7:0]   s2_tdata;
    logic         s2_tvalid;
    logic         s2_tready;
    logic [255:0] tdata;
    logic         tvalid;
    logic         tready;
    logic [7:0]   src;
    logic [7:0]   dst;
    logic [31:0]  beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    lii_stream_packer dut (
        .aclk(aclk), .arstn(arstn),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tready(s2_tready),
        .lii_out_p0_tdata(tdata), .lii_out_p0_tvalid(tvalid), .lii_out_p0_tready(tready),
        .lii_out_p0_src(src), .lii_out_p0_dst(dst), .beat_cnt(beat_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic cmp(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pk(input logic [127:0] a, input logic [7:0] b, input logic [7:0] c);
        return {112'd0, c, b, a};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // AXI-S stability: a stalled beat must stay valid with unchanged data
    logic         m_stall = 1'b0;
    logic [255:0] m_prev  = '0;
    always @(negedge aclk) begin
        if (arstn && m_stall) begin
            cmp("stall_valid", 256'(tvalid), 256'(1'b1));
            cmp("stall_data", tdata, m_prev);
        end
        m_stall <= arstn && tvalid && !tready;
        m_prev  <= tdata;
    end

    task automatic stream(input int n, input int pv, input int pr, input int stall,
                          output int cyc, output int acc_stall);
        logic [127:0] d0[$];
        logic [7:0]   d1[$];
        logic [7:0]   d2[$];
        logic [255:0] rx[$];
        int i0 = 0, i1 = 0, i2 = 0;
        logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
        for (int k = 0; k < n; k++) begin
            d0.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            d1.push_back(8'($urandom()));
            d2.push_back(8'($urandom()));
        end
        cyc = 0;
        acc_stall = 0;
        while (rx.size() < n && cyc < n * 20 + 50) begin
            step();
            cyc++;
            if (!s0_tvalid || a0) begin
                s0_tvalid = (i0 < n) && (int'($urandom_range(99)) < pv);
                s0_tdata  = (i0 < n) ? d0[i0] : '0;
            end
            if (!s1_tvalid || a1) begin
                s1_tvalid = (i1 < n) && (int'($urandom_range(99)) < pv);
                s1_tdata  = (i1 < n) ? d1[i1] : '0;
            end
            if (!s2_tvalid || a2) begin
                s2_tvalid = (i2 < n) && (int'($urandom_range(99)) < pv);
                s2_tdata  = (i2 < n) ? d2[i2] : '0;
            end
            tready = (cyc > stall) && (int'($urandom_range(99)) < pr);
            @(negedge aclk);
            a0 = s0_tvalid & s0_tready;
            a1 = s1_tvalid & s1_tready;
            a2 = s2_tvalid & s2_tready;
            if (a0) i0++;
            if (a1) i1++;
            if (a2) i2++;
            if (cyc == stall) acc_stall = i0;
            if (tvalid && tready) rx.push_back(tdata);
        end
        cmp("stream_count", 256'(rx.size()), 256'(n));
        for (int k = 0; k < rx.size(); k++) cmp("stream_beat", rx[k], pk(d0[k], d1[k], d2[k]));
        step();
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        s2_tvalid = 1'b0;
        tready    = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        int cyc, acc;
        logic [127:0] p0;
        arstn     = 1'b0;
        s0_tdata  = '0; s0_tvalid = 1'b0;
        s1_tdata  = '0; s1_tvalid = 1'b0;
        s2_tdata  = '0; s2_tvalid = 1'b0;
        tready    = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        arstn = 1'b1;
        @(negedge aclk);
        cmp("rst_tvalid", 256'(tvalid), 256'(1'b0));
        cmp("rst_tdata", tdata, 256'd0);
        cmp("rst_cnt", 256'(beat_cnt), 256'd0);
        cmp("rst_ready", 256'({s0_tready, s1_tready, s2_tready}), 256'(3'b111));
        cmp("src", 256'(src), 256'(8'd0));
        cmp("dst", 256'(dst), 256'(8'd1));

        // Single beat: accept at edge t, valid visible only after edge t+1
        p0 = 128'h0123456789ABCDEF0123456789ABCDEF;
        step();
        tready = 1'b1;
        s0_tdata = p0;    s0_tvalid = 1'b1;
        s1_tdata = 8'hA5; s1_tvalid = 1'b1;
        s2_tdata = 8'h3C; s2_tvalid = 1'b1;
        @(negedge aclk);
        step();
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s2_tvalid = 1'b0;
        @(negedge aclk);
        cmp("single_early", 256'(tvalid), 256'(1'b0));
        step();
        @(negedge aclk);
        cmp("single_valid", 256'(tvalid), 256'(1'b1));
        cmp("single_data", tdata, {112'd0, 8'h3C, 8'hA5, 128'h0123456789ABCDEF0123456789ABCDEF});
        step();
        @(negedge aclk);
        cmp("single_once", 256'(tvalid), 256'(1'b0));
        cmp("single_cnt", 256'(beat_cnt), 256'd1);
        exp_cnt = 1;

        // Staggered lanes: early lane stalls only itself
        for (int c = 0; c < 10; c++) begin
            step();
            s0_tvalid = (c == 0); s0_tdata = 128'hFEED;
            s1_tvalid = (c == 3); s1_tdata = 8'h11;
            s2_tvalid = (c == 7); s2_tdata = 8'h22;
            @(negedge aclk);
            if (c >= 1 && c <= 7) cmp("stag_s0_ready", 256'(s0_tready), 256'(1'b0));
            if (c <= 8) cmp("stag_no_beat", 256'(tvalid), 256'(1'b0));
            if (c == 9) begin
                cmp("stag_valid", 256'(tvalid), 256'(1'b1));
                cmp("stag_data", tdata, pk(128'hFEED, 8'h11, 8'h22));
            end
        end
        step();
        @(negedge aclk);
        exp_cnt++;
        cmp("stag_cnt", 256'(beat_cnt), 256'(exp_cnt));

        // Sink stall: only two sets fit (output + holding) while tready is low
        stream(3, 100, 100, 10, cyc, acc);
        cmp("stall_accepted", 256'(acc), 256'd2);
        exp_cnt += 3;
        cmp("stall_cnt", 256'(beat_cnt), 256'(exp_cnt));

        // Streaming throughput: one beat per cycle
        stream(1000, 100, 100, 0, cyc, acc);
        n_cmp++;
        assert (cyc >= 1001 && cyc <= 1002) else begin
            n_err++;
            $error("FAIL thru_cycles: observed %0d expected 1001..1002", cyc);
        end
        exp_cnt += 1000;
        cmp("thru_cnt", 256'(beat_cnt), 256'(exp_cnt));

        // Random valids and backpressure
        stream(300, 50, 50, 0, cyc, acc);
        exp_cnt += 300;
        cmp("rand_cnt", 256'(beat_cnt), 256'(exp_cnt));

        // Reset mid-operation: output valid and lane 0 full
        tready = 1'b0;
        step();
        s0_tdata = 128'hAAAA; s0_tvalid = 1'b1;
        s1_tdata = 8'h01;     s1_tvalid = 1'b1;
        s2_tdata = 8'h02;     s2_tvalid = 1'b1;
        @(negedge aclk);
        step();
        s0_tdata = 128'hBBBB; s1_tvalid = 1'b0; s2_tvalid = 1'b0;
        @(negedge aclk);
        step();
        s0_tvalid = 1'b0;
        @(negedge aclk);
        cmp("pre_rst_valid", 256'(tvalid), 256'(1'b1));
        cmp("pre_rst_s0_full", 256'(s0_tready), 256'(1'b0));
        #2;
        arstn = 1'b0;
        #1;
        cmp("async_tvalid", 256'(tvalid), 256'(1'b0));
        cmp("async_cnt", 256'(beat_cnt), 256'd0);
        cmp("async_tdata", tdata, 256'd0);
        step();
        step();
        arstn = 1'b1;
        @(negedge aclk);
        cmp("post_rst_ready", 256'({s0_tready, s1_tready, s2_tready}), 256'(3'b111));
        tready = 1'b1;
        step();
        s0_tdata = 128'hCCCC; s0_tvalid = 1'b1;
        s1_tdata = 8'h33;     s1_tvalid = 1'b1;
        s2_tdata = 8'h44;     s2_tvalid = 1'b1;
        @(negedge aclk);
        step();
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s2_tvalid = 1'b0;
        @(negedge aclk);
        cmp("post_rst_early", 256'(tvalid), 256'(1'b0));
        step();
        @(negedge aclk);
        cmp("post_rst_valid", 256'(tvalid), 256'(1'b1));
        cmp("post_rst_data", tdata, pk(128'hCCCC, 8'h33, 8'h44));
        step();
        @(negedge aclk);
        cmp("post_rst_cnt", 256'(beat_cnt), 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
